jtag_tap_param: RTL and testbench

Parametrised IEEE 1149.1 TAP controller: the successor to the fixed 4-bit-IR ARM7TDMI TAP.
- Generic IR width and configurable IDCODE value and opcodes.
- N user data-register chains, each with a decoded select and a TDO mux.
- Provides the 16-state TAP FSM, IR shift/update, and the BYPASS and IDCODE registers.
- Sits between the JTAG pins and the debug logic (ICE, scan-chain select, etc.).

---
 rtl/jtag_pkg.sv | 55 +++++
 rtl/jtag_tap_fsm.sv | 29 ++
 rtl/jtag_tap_param.sv | 127 ++++++++++++
 tb/tb_jtag_tap_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding in IEEE table order, default opcodes,
// and the 16-state next-state function used by the FSM and the datapath.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR_SCAN   = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR_SCAN   = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_e;

    localparam logic [3:0]  JTAG_IDCODE_OP  = 4'hE;
    localparam logic [3:0]  JTAG_BYPASS_OP  = 4'hF;
    localparam logic [3:0]  JTAG_INTEST_OP  = 4'hC;
    localparam logic [3:0]  JTAG_SCAN_N_OP  = 4'h2;
    localparam logic [31:0] JTAG_IDCODE_VAL = 32'h0F0F0F0F;

    function automatic tap_state_e jtag_next_state(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TEST_LOGIC_RESET;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register plus next-state logic only.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_e tap_state
);

    tap_state_e r_state;
    tap_state_e w_state_next;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_state_next = jtag_next_state(r_state, tms);
    end

    assign tap_state = r_state;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP: FSM plus IR, BYPASS, IDCODE and N user DR selects/TDO mux.
// Define JTAG_IR_STATUS_EN to capture ir_status into the upper IR bits.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = 4,
    parameter logic [31:0]           IDCODE_VAL   = JTAG_IDCODE_VAL,
    parameter logic [IR_WIDTH-1:0]   IDCODE_OP    = IR_WIDTH'(JTAG_IDCODE_OP),
    parameter logic [IR_WIDTH-1:0]   BYPASS_OP    = '1,
    parameter int                    NUM_USER_DR  = 2,
    parameter logic [IR_WIDTH-1:0]   USER_OP_BASE = IR_WIDTH'(JTAG_SCAN_N_OP)
) (
    input  logic                   tck,
    input  logic                   trst_n,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic                   tdo_en,
    output logic [3:0]             tap_state,
    output logic                   capture_dr,
    output logic                   shift_dr,
    output logic                   update_dr,
    output logic [IR_WIDTH-1:0]    current_ir,
    output logic [NUM_USER_DR-1:0] user_sel,
    input  logic [NUM_USER_DR-1:0] user_tdo,
    input  logic [IR_WIDTH-3:0]    ir_status
);

    tap_state_e              w_state;
    tap_state_e              w_state_next;
    logic [IR_WIDTH-1:0]     r_ir_shift;
    logic [IR_WIDTH-1:0]     r_current_ir;
    logic [31:0]             r_idcode;
    logic                    r_bypass;
    logic [IR_WIDTH-1:0]     w_ir_capture;
    logic                    w_sel_idcode;
    logic                    w_sel_bypass;
    logic [NUM_USER_DR-1:0]  w_user_sel;
    logic                    w_dr_tdo;
    logic                    w_tdo;

    jtag_tap_fsm u_fsm (
        .tck       (tck),
        .trst_n    (trst_n),
        .tms       (tms),
        .tap_state (w_state)
    );

    assign w_state_next = jtag_next_state(w_state, tms);

`ifdef JTAG_IR_STATUS_EN
    assign w_ir_capture = {ir_status, 2'b01};
`else
    logic w_unused_status;
    assign w_ir_capture    = {{(IR_WIDTH-2){1'b0}}, 2'b01};
    assign w_unused_status = ^ir_status;
`endif

    assign w_sel_idcode = (r_current_ir == IDCODE_OP);
    assign w_sel_bypass = (r_current_ir == BYPASS_OP);

    // IDCODE/BYPASS take precedence over any user opcode that aliases them
    for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_user_sel
        assign w_user_sel[gi] = (r_current_ir == USER_OP_BASE + IR_WIDTH'(gi))
                                && !w_sel_idcode && !w_sel_bypass;
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_shift   <= '0;
            r_current_ir <= IDCODE_OP;
            r_idcode     <= '0;
            r_bypass     <= 1'b0;
        end else begin
            case (w_state)
                CAPTURE_IR: r_ir_shift <= w_ir_capture;
                SHIFT_IR:   r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
                CAPTURE_DR: begin
                    r_idcode <= IDCODE_VAL;
                    r_bypass <= 1'b0;
                end
                SHIFT_DR: begin
                    if (w_sel_idcode) begin
                        r_idcode <= {tdi, r_idcode[31:1]};
                    end
                    r_bypass <= tdi;
                end
                default: ;
            endcase
            // Forcing on entry makes IDCODE visible as soon as TLR is reached
            if (w_state_next == TEST_LOGIC_RESET) begin
                r_current_ir <= IDCODE_OP;
            end else if (w_state == UPDATE_IR) begin
                r_current_ir <= r_ir_shift;
            end
        end
    end

    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_sel_idcode) begin
            w_dr_tdo = r_idcode[0];
        end else begin
            for (int i = 0; i < NUM_USER_DR; i++) begin
                if (w_user_sel[i]) begin
                    w_dr_tdo = user_tdo[i];
                end
            end
        end
        w_tdo = 1'b0;
        if (w_state == SHIFT_IR) begin
            w_tdo = r_ir_shift[0];
        end else if (w_state == SHIFT_DR) begin
            w_tdo = w_dr_tdo;
        end
    end

    assign tdo        = w_tdo;
    assign tdo_en     = (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
    assign tap_state  = w_state;
    assign capture_dr = (w_state == CAPTURE_DR);
    assign shift_dr   = (w_state == SHIFT_DR);
    assign update_dr  = (w_state == UPDATE_DR);
    assign current_ir = r_current_ir;
    assign user_sel   = w_user_sel;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param (default parameters); inputs change on the
// falling edge of tck, outputs are sampled in the low phase.
module tb_jtag_tap_param;
    import jtag_pkg::*;

    logic       tck;
    logic       trst_n;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] tap_state;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [3:0] current_ir;
    logic [1:0] user_sel;
    logic [1:0] user_tdo;
    logic [1:0] ir_status;

    int n_checks = 0;
    int n_errors = 0;

    jtag_tap_param dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .tap_state  (tap_state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .current_ir (current_ir),
        .user_sel   (user_sel),
        .user_tdo   (user_tdo),
        .ir_status  (ir_status)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end else begin
            $display("check %s: %h ok", tag, obs);
        end
    endtask

    // one TAP clock with the given tms/tdi; returns in the next low phase
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
    endtask

    // from RUN_TEST_IDLE: load IR, end in RUN_TEST_IDLE
    task automatic load_ir(input logic [3:0] op);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1, 0);
        step(0, 0);
    endtask

    logic [31:0] word;
    logic [3:0]  ir_bits;
    logic [7:0]  bits8;
    logic [7:0]  byp_in;
    logic [1:0]  two;
    logic [3:0]  exp_ir_tdo;
    logic [3:0]  exp_pause_ir;

    initial begin
`ifdef JTAG_IR_STATUS_EN
        exp_ir_tdo   = 4'b1001;
        exp_pause_ir = 4'h4;
`else
        exp_ir_tdo   = 4'b0001;
        exp_pause_ir = 4'h0;
`endif
        trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; user_tdo = 2'b00; ir_status = 2'b10;
        @(negedge tck); @(negedge tck);
        check("reset_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("reset_ir", 32'(current_ir), 32'hE);
        check("reset_tdo_en", 32'(tdo_en), 32'h0);
        check("reset_tdo", 32'(tdo), 32'h0);
        check("reset_dr_flags", {29'd0, capture_dr, shift_dr, update_dr}, 32'h0);
        check("reset_user_sel", 32'(user_sel), 32'h0);
        trst_n = 1'b1;
        @(negedge tck);

        // IDCODE read straight after reset
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        check("idcode_state", 32'(tap_state), 32'(SHIFT_DR));
        check("idcode_tdo_en", {30'd0, tdo_en, shift_dr}, 32'h3);
        for (int i = 0; i < 32; i++) begin
            word[i] = tdo;
            if (i == 0) check("idcode_first_bit", 32'(tdo), 32'h1);
            step(i == 31, 0);
        end
        check("idcode_stream", word, 32'h0F0F0F0F);
        step(1, 0);
        check("update_dr", 32'(update_dr), 32'h1);
        step(0, 0);
        check("rti_state", 32'(tap_state), 32'(RUN_TEST_IDLE));

        // async reset in the middle of a DR shift
        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        trst_n = 1'b0;
        #1;
        check("trst_dr_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("trst_dr_tdo_en", {30'd0, tdo_en, shift_dr}, 32'h0);
        check("trst_dr_ir", 32'(current_ir), 32'hE);
        #1 trst_n = 1'b1;
        @(negedge tck);

        // IR load 0xC and observe the captured pattern on tdo
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check("ir_tdo_en", 32'(tdo_en), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ir_bits[i] = tdo;
            step(i == 3, (i >= 2) ? 1'b1 : 1'b0);
        end
        check("ir_capture_tdo", 32'(ir_bits), 32'(exp_ir_tdo));
        step(1, 0);
        check("ir_in_update", 32'(current_ir), 32'hE);
        step(0, 0);
        check("ir_loaded_c", 32'(current_ir), 32'hC);
        check("ir_c_user_sel", 32'(user_sel), 32'h0);

        // PAUSE_IR holds; 4 tms=1 edges are not enough, the 5th reaches TLR
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(1, 0); step(0, 0); step(0, 1); step(0, 1); step(0, 1);
        check("pause_ir_state", 32'(tap_state), 32'(PAUSE_IR));
        check("pause_ir_hold", 32'(current_ir), 32'hC);
        for (int i = 0; i < 4; i++) step(1, 0);
        check("tms4_not_reset", 32'(tap_state), 32'(SELECT_IR_SCAN));
        check("pause_ir_update", 32'(current_ir), 32'(exp_pause_ir));
        step(1, 0);
        check("tms5_reset", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("tms5_ir", 32'(current_ir), 32'hE);

        // BYPASS: one-edge delay, first bit is the captured 0
        step(0, 0);
        load_ir(4'hF);
        check("bypass_ir", 32'(current_ir), 32'hF);
        step(1, 0); step(0, 0); step(0, 0);
        byp_in = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            bits8[k] = tdo;
            step(k == 7, byp_in[k]);
        end
        check("bypass_stream", 32'(bits8), 32'h9A);
        step(1, 0); step(0, 0);

        // user chain 1
        load_ir(4'h3);
        check("user3_sel", 32'(user_sel), 32'h2);
        user_tdo = 2'b10;
        #1;
        check("user_tdo_idle", 32'(tdo), 32'h0);
        step(1, 0); step(0, 0);
        check("user_capture_dr", 32'(capture_dr), 32'h1);
        step(0, 0);
        check("user_tdo_hi", 32'(tdo), 32'h1);
        user_tdo = 2'b01;
        #1;
        check("user_tdo_lo", 32'(tdo), 32'h0);
        user_tdo = 2'b11;
        #1;
        check("user_tdo_hi2", 32'(tdo), 32'h1);
        step(1, 0);
        check("user_tdo_exit", 32'(tdo), 32'h0);
        step(1, 0); step(0, 0);
        user_tdo = 2'b00;

        load_ir(4'h2);
        check("user2_sel", 32'(user_sel), 32'h1);

        // unmapped opcode falls back to bypass
        load_ir(4'h5);
        check("unmapped_sel", 32'(user_sel), 32'h0);
        step(1, 0); step(0, 0); step(0, 0);
        two[0] = tdo;
        step(0, 1);
        two[1] = tdo;
        step(1, 1);
        check("unmapped_bypass", 32'(two), 32'h2);
        step(1, 0); step(0, 0);

        // async reset in the middle of an IR shift discards it
        load_ir(4'h3);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        trst_n = 1'b0;
        #1;
        check("trst_ir_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("trst_ir_ir", 32'(current_ir), 32'hE);
        check("trst_ir_user_sel", 32'(user_sel), 32'h0);
        #1 trst_n = 1'b1;
        @(negedge tck);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
